// File: rtl/sym_pkg.sv
// Shared game-flow types, segment constants and the active-low digit decoder
// used by the sequencer and the post-period display.
package sym_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      GEN   = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4,
      FAULT = 3'd5
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_P     = 8'b10001100;
   localparam logic [7:0] SEG_E     = 8'b10000110;

   // Active-low segments, bit 7 is the decimal point (always off).
   function automatic logic [7:0] int_to_seg(input logic [6:0] i_val);
      logic [7:0] w_seg;
      case (i_val)
         7'd0:    w_seg = 8'b11000000;
         7'd1:    w_seg = 8'b11111001;
         7'd2:    w_seg = 8'b10100100;
         7'd3:    w_seg = 8'b10110000;
         7'd4:    w_seg = 8'b10011001;
         7'd5:    w_seg = 8'b10010010;
         7'd6:    w_seg = 8'b10000010;
         7'd7:    w_seg = 8'b11111000;
         7'd8:    w_seg = 8'b10000000;
         7'd9:    w_seg = 8'b10010000;
         default: w_seg = SEG_BLANK;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/level_sequencer_sec_down_counter.sv
// Loadable 7-bit seconds counter; lastTick marks the tick that ends a phase.
module sec_down_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [6:0] i_load_val,
   input  logic       i_tick,
   output logic [6:0] o_cnt,
   output logic       o_last_tick
);

   logic [6:0] r_cnt;

   // A load on the same edge as a tick wins, so the entry tick is never counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 7'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_tick && (r_cnt != 7'd0)) begin
         r_cnt <= r_cnt - 7'd1;
      end
   end

   assign o_cnt       = r_cnt;
   assign o_last_tick = i_tick & (r_cnt == 7'd1);

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: countdown, generation window and post period per level,
// with start pulse to the post-period block and completion/fault reporting.
module level_sequencer
   import sym_pkg::*;
#(
   parameter int NUM_LEVELS   = 4,
   parameter int PRE_SECONDS  = 3,
   parameter int GEN_SECONDS  = 10,
   parameter int POST_TIMEOUT = 8
) (
   input  logic       Clk100M,
   input  logic       Reset,
   input  logic       tick1Hz,
   input  logic       startBtn,
   input  logic       levelComplete,
   output logic       genEnable,
   output logic       postSig,
   output logic [3:0] level,
   output logic       gameDone,
   output logic       fault,
   output logic [7:0] statSeg2,
   output logic [7:0] statSeg3
);

   localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
   localparam logic [6:0] PRE_LOAD   = 7'(PRE_SECONDS);
   localparam logic [6:0] GEN_LOAD   = 7'(GEN_SECONDS);
   localparam logic [6:0] POST_LOAD  = 7'(POST_TIMEOUT);

   state_t     r_state;
   logic [3:0] r_level;
   logic       r_gen;
   logic       r_post;
   logic       r_done;
   logic       r_fault;
   logic [7:0] r_seg2;
   logic [7:0] r_seg3;

   logic       w_tick;
   logic       w_last;
   logic       w_load;
   logic [6:0] w_load_val;
   logic [6:0] w_cnt;
   logic       w_more_levels;

   // Ticks only matter while a timed phase is running.
   assign w_tick        = tick1Hz & ((r_state == PRE) | (r_state == GEN) | (r_state == POST));
   assign w_more_levels = (r_level < LAST_LEVEL);

   always_comb begin
      w_load     = 1'b0;
      w_load_val = PRE_LOAD;
      case (r_state)
         IDLE, DONE: w_load = startBtn;
         PRE: begin
            w_load     = w_last;
            w_load_val = GEN_LOAD;
         end
         GEN: begin
            w_load     = w_last;
            w_load_val = POST_LOAD;
         end
         POST:    w_load = levelComplete & w_more_levels;
         default: w_load = 1'b0;
      endcase
   end

   sec_down_counter u_sec_cnt (
      .clk         (Clk100M),
      .rst         (Reset),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .i_tick      (w_tick),
      .o_cnt       (w_cnt),
      .o_last_tick (w_last)
   );

   always_ff @(posedge Clk100M or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_level <= 4'd0;
         r_gen   <= 1'b0;
         r_post  <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         r_seg2  <= SEG_BLANK;
         r_seg3  <= SEG_BLANK;
      end else begin
         r_post <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (startBtn) begin
                  r_state <= PRE;
                  r_level <= 4'd0;
                  r_done  <= 1'b0;
                  r_seg2  <= int_to_seg(7'd1);
                  r_seg3  <= int_to_seg(PRE_LOAD);
               end
            end
            PRE: begin
               if (w_last) begin
                  r_state <= GEN;
                  r_gen   <= 1'b1;
                  r_seg3  <= SEG_BLANK;
               end else if (w_tick) begin
                  r_seg3 <= int_to_seg(w_cnt - 7'd1);
               end
            end
            GEN: begin
               if (w_last) begin
                  r_state <= POST;
                  r_gen   <= 1'b0;
                  r_post  <= 1'b1;
               end
            end
            POST: begin
               // Completion beats a coincident timeout tick.
               if (levelComplete) begin
                  if (w_more_levels) begin
                     r_state <= PRE;
                     r_level <= r_level + 4'd1;
                     r_seg2  <= int_to_seg({3'b000, r_level} + 7'd2);
                     r_seg3  <= int_to_seg(PRE_LOAD);
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_seg3  <= SEG_P;
                  end
               end else if (w_last) begin
                  r_state <= FAULT;
                  r_fault <= 1'b1;
                  r_seg3  <= SEG_E;
               end
            end
            FAULT:   r_state <= FAULT;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign genEnable = r_gen;
   assign postSig   = r_post;
   assign level     = r_level;
   assign gameDone  = r_done;
   assign fault     = r_fault;
   assign statSeg2  = r_seg2;
   assign statSeg3  = r_seg3;

endmodule

// File: tb/tb_level_sequencer.sv
// Randomized plus directed bench for level_sequencer against a phase-level model.
module tb_level_sequencer;

   localparam int NL = 4;
   localparam int PS = 3;
   localparam int GS = 10;
   localparam int PT = 8;

   localparam int PH_IDLE  = 0;
   localparam int PH_PRE   = 1;
   localparam int PH_GEN   = 2;
   localparam int PH_POST  = 3;
   localparam int PH_DONE  = 4;
   localparam int PH_FAULT = 5;

   logic       Clk100M = 1'b0;
   logic       Reset = 1'b1;
   logic       tick1Hz = 1'b0;
   logic       startBtn = 1'b0;
   logic       levelComplete = 1'b0;
   logic       genEnable;
   logic       postSig;
   logic [3:0] level;
   logic       gameDone;
   logic       fault;
   logic [7:0] statSeg2;
   logic [7:0] statSeg3;

   int checks = 0;
   int errors = 0;

   int m_ph    = PH_IDLE;
   int m_sec   = 0;
   int m_lvl   = 0;
   bit m_pulse = 1'b0;

   level_sequencer #(
      .NUM_LEVELS   (NL),
      .PRE_SECONDS  (PS),
      .GEN_SECONDS  (GS),
      .POST_TIMEOUT (PT)
   ) dut (
      .Clk100M       (Clk100M),
      .Reset         (Reset),
      .tick1Hz       (tick1Hz),
      .startBtn      (startBtn),
      .levelComplete (levelComplete),
      .genEnable     (genEnable),
      .postSig       (postSig),
      .level         (level),
      .gameDone      (gameDone),
      .fault         (fault),
      .statSeg2      (statSeg2),
      .statSeg3      (statSeg3)
   );

   always #5 Clk100M = ~Clk100M;

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Displays and flags follow directly from the abstract game phase.
   function automatic logic [23:0] expected_outs();
      logic [7:0] s2;
      logic [7:0] s3;
      s2 = (m_ph == PH_IDLE) ? 8'hFF : seg_of(m_lvl + 1);
      if (m_ph == PH_PRE)        s3 = seg_of(m_sec);
      else if (m_ph == PH_DONE)  s3 = 8'h8C;
      else if (m_ph == PH_FAULT) s3 = 8'h86;
      else                       s3 = 8'hFF;
      return {m_ph == PH_GEN, m_pulse, 4'(m_lvl), m_ph == PH_DONE, m_ph == PH_FAULT, s2, s3};
   endfunction

   task automatic model_reset();
      m_ph    = PH_IDLE;
      m_sec   = 0;
      m_lvl   = 0;
      m_pulse = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit t, input bit lc);
      m_pulse = 1'b0;
      case (m_ph)
         PH_IDLE, PH_DONE: if (s) begin m_ph = PH_PRE; m_lvl = 0; m_sec = PS; end
         PH_PRE: if (t) begin
            if (m_sec == 1) begin m_ph = PH_GEN; m_sec = GS; end
            else m_sec = m_sec - 1;
         end
         PH_GEN: if (t) begin
            if (m_sec == 1) begin m_ph = PH_POST; m_sec = PT; m_pulse = 1'b1; end
            else m_sec = m_sec - 1;
         end
         PH_POST: begin
            if (lc) begin
               if (m_lvl < NL - 1) begin m_lvl = m_lvl + 1; m_ph = PH_PRE; m_sec = PS; end
               else m_ph = PH_DONE;
            end else if (t) begin
               if (m_sec == 1) m_ph = PH_FAULT;
               else m_sec = m_sec - 1;
            end
         end
         default: ;
      endcase
   endtask

   always @(posedge Reset) model_reset();

   // Per-cycle comparison of every output against the model.
   always @(posedge Clk100M) begin
      logic [23:0] exp_v;
      logic [23:0] act_v;
      if (Reset) model_reset();
      else model_step(startBtn, tick1Hz, levelComplete);
      #2;
      exp_v = expected_outs();
      act_v = {genEnable, postSig, level, gameDone, fault, statSeg2, statSeg3};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit s, input bit t, input bit lc);
      @(negedge Clk100M);
      startBtn = s;
      tick1Hz = t;
      levelComplete = lc;
      @(posedge Clk100M);
      #3;
      startBtn = 1'b0;
      tick1Hz = 1'b0;
      levelComplete = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic tk(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         idle(1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge Clk100M);
      @(negedge Clk100M);
      Reset = 1'b0;
      #1;
      chk("reset_outputs", {genEnable, postSig, level, gameDone, fault, statSeg2, statSeg3}, 24'h0000FF_FF);

      drive(1'b0, 1'b0, 1'b1);
      chk("stray_lc_idle", statSeg2, 8'hFF);
      drive(1'b1, 1'b0, 1'b0);
      chk("pre_digit_3", statSeg3, 8'hB0);
      chk("level_digit_1", statSeg2, 8'hF9);
      drive(1'b0, 1'b0, 1'b1);
      chk("stray_lc_pre", statSeg3, 8'hB0);
      tk(1);
      chk("pre_digit_2", statSeg3, 8'hA4);
      tk(1);
      chk("pre_digit_1", statSeg3, 8'hF9);
      drive(1'b0, 1'b1, 1'b0);
      chk("gen_rises", genEnable, 1'b1);
      chk("gen_seg3_blank", statSeg3, 8'hFF);
      drive(1'b0, 1'b0, 1'b1);
      chk("stray_lc_gen", genEnable, 1'b1);
      tk(GS - 1);
      drive(1'b0, 1'b1, 1'b0);
      chk("post_pulse", {genEnable, postSig}, 2'b01);
      idle(1);
      chk("post_pulse_end", postSig, 1'b0);
      idle(19);
      drive(1'b0, 1'b0, 1'b1);
      chk("level_1", level, 4'd1);
      chk("level_digit_2", statSeg2, 8'hA4);

      for (int l = 1; l < NL; l++) begin
         tk(PS + GS);
         idle(5);
         drive(1'b0, 1'b0, 1'b1);
      end
      chk("game_done", {gameDone, statSeg3, statSeg2}, {1'b1, 8'h8C, 8'h99});
      drive(1'b1, 1'b0, 1'b0);
      chk("restart", {gameDone, level, statSeg3}, {1'b0, 4'd0, 8'hB0});

      tk(PS + GS + PT - 1);
      chk("no_fault_yet", fault, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      chk("fault", {fault, statSeg3}, {1'b1, 8'h86});
      drive(1'b1, 1'b0, 1'b0);
      chk("fault_ignores_start", fault, 1'b1);
      @(negedge Clk100M);
      #2 Reset = 1'b1;
      #1 chk("reset_clears_fault", {fault, statSeg3}, {1'b0, 8'hFF});
      @(negedge Clk100M);
      Reset = 1'b0;

      drive(1'b1, 1'b0, 1'b0);
      tk(PS + GS + PT - 1);
      drive(1'b0, 1'b1, 1'b1);
      chk("collision_level", {level, fault, statSeg3}, {4'd1, 1'b0, 8'hB0});

      tk(PS + 3);
      chk("mid_gen", genEnable, 1'b1);
      @(posedge Clk100M);
      #3 Reset = 1'b1;
      #1 chk("async_reset", {genEnable, postSig, level}, 6'd0);
      repeat (3) @(negedge Clk100M);
      Reset = 1'b0;
      idle(3);
      chk("idle_after_reset", {genEnable, statSeg2}, {1'b0, 8'hFF});

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            @(negedge Clk100M);
            Reset = 1'b1;
            @(negedge Clk100M);
            Reset = 1'b0;
         end else begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 11) == 0);
         end
      end

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
